// File: rtl/nios2_cpu_key_in_pkg.sv
// Shared constants for the key/switch input PIO.
// Register map offsets and edge-capture selection codes.
package nios2_cpu_key_in_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Counter width that can hold 0..cycles, never zero wide.
  function automatic int cnt_width(input int cycles);
    return (cycles > 0) ? $clog2(cycles + 1) : 1;
  endfunction

  // Pick the captured edge set for the configured edge type.
  function automatic logic edge_pick(
    input int   kind,
    input logic rise,
    input logic fall
  );
    logic hit;
    hit = 1'b0;
    if (kind == EDGE_RISE) begin
      hit = rise;
    end else if (kind == EDGE_FALL) begin
      hit = fall;
    end else begin
      hit = rise | fall;
    end
    return hit;
  endfunction

endpackage

// File: rtl/nios2_cpu_key_debounce.sv
// One input pin: metastability synchroniser then a
// hold-time debouncer that only accepts long-lived levels.
module nios2_cpu_key_debounce
  import nios2_cpu_key_in_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   sync;
  logic                   stable;

  assign sync  = chain[SYNC_STAGES-1];
  assign level = stable;

  // Shift the raw pin through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pin};
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass

      // No filtering: follow the synchronised pin directly.
      always_ff @(posedge clk) begin
        if (reset) begin
          stable <= 1'b0;
        end else begin
          stable <= sync;
        end
      end

    end else begin : g_filter

      localparam int CW = cnt_width(DEBOUNCE_CYCLES);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt;

      // Count how long sync has differed; accept on the last count.
      always_ff @(posedge clk) begin
        if (reset) begin
          stable <= 1'b0;
          cnt    <= '0;
        end else if (sync == stable) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          stable <= sync;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

    end
  endgenerate

endmodule

// File: rtl/nios2_cpu_key_in.sv
// Avalon-MM input PIO for push-buttons and switches.
// Debounced data, edge capture with W1C, maskable irq.
module nios2_cpu_key_in
  import nios2_cpu_key_in_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] wdata;
  logic             wr;
  logic             wr_mask;
  logic             wr_edge;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      nios2_cpu_key_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_deb (
        .clk   (clk),
        .reset (reset),
        .pin   (in_port[i]),
        .level (stable[i])
      );
    end
  endgenerate

  generate
    if (WIDTH < 32) begin : g_unused
      logic unused_wdata;
      assign unused_wdata = ^writedata[31:WIDTH];
    end
  endgenerate

  assign wdata   = writedata[WIDTH-1:0];
  assign wr      = chipselect & ~write_n;
  assign wr_mask = wr & (address == ADDR_MASK);
  assign wr_edge = wr & (address == ADDR_EDGE);

  assign rise = stable & ~stable_d;
  assign fall = ~stable & stable_d;

  // Select which transitions latch into edge_capture.
  always_comb begin
    hit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hit[i] = edge_pick(EDGE_TYPE, rise[i], fall[i]);
    end
  end

  assign clr = wr_edge ? wdata : '0;

  // Delay the debounced level for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_d <= '0;
    end else begin
      stable_d <= stable;
    end
  end

  // Interrupt mask register, loaded by CPU writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= '0;
    end else if (wr_mask) begin
      irq_mask <= wdata;
    end
  end

  // Edge capture: W1C clear, a same-cycle set takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~clr) | hit;
    end
  end

  assign irq = |(edge_capture & irq_mask);

  // Zero-wait read mux, zero-extended above WIDTH.
  always_comb begin
    readdata = '0;
    unique case (address)
      ADDR_DATA: readdata = 32'(stable);
      ADDR_RSVD: readdata = '0;
      ADDR_MASK: readdata = 32'(irq_mask);
      ADDR_EDGE: readdata = 32'(edge_capture);
      default:   readdata = '0;
    endcase
  end

endmodule
